conv_result_writer: RTL

CONV_RESULT_WRITER -- requirements
Module: conv_result_writer

---
 rtl/conv_pkg.sv | 17 +
 rtl/result_fifo.sv | 55 +++++
 rtl/conv_result_writer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution result writer.
//
// Contents:
//   DATA_WIDTH_DEF  default adder-tree sum width: a 19-bit sum plus one carry bit
//   state_e         frame sequencing states used by conv_result_writer
package conv_pkg;

  localparam int SUM_WIDTH_DEF  = 19;
  localparam int DATA_WIDTH_DEF = SUM_WIDTH_DEF + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO that buffers adder-tree sums ahead of the memory writer.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset; empties the FIFO
//   push_i        write push_data_i (taken when not full, or when a pop happens in the same cycle)
//   push_data_i   entry to store
//   pop_i         drop the head entry (ignored when empty)
//   head_o        current head entry
//   full_o        all DEPTH entries occupied
//   empty_o       no entries stored
module result_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bits means full.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/conv_result_writer.sv
// Collects one frame of NUM_RESULTS signed adder-tree sums and writes them to
// the result memory at consecutive addresses 0..NUM_RESULTS-1.
//
// Optional feature: define RESULT_RELU_EN to clamp negative sums (MSB set)
// to zero as they enter the buffer; without it sums are written unmodified.
//
// Ports:
//   clk, reset         clock and asynchronous active-low reset
//   enable             frame start, sampled only while idle
//   in_valid/in_num    producer side; transfer when in_valid && in_ready
//   in_ready           room in the buffer and frame not yet fully accepted
//   mem_req/mem_ack    memory write handshake; address/data held until ack
//   mem_addr/mem_wdata write address and data
//   busy               frame in progress
//   done               one-cycle pulse after the last write completes
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is combinational; mem_req is a register that, once
// raised, keeps mem_addr/mem_wdata stable until the edge that samples mem_ack.
module conv_result_writer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int NUM_RESULTS = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_num,
  output logic                  in_ready,
  output logic                  mem_req,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done
);

  localparam int             CNT_W     = $clog2(NUM_RESULTS + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(NUM_RESULTS);
  localparam logic [CNT_W-1:0] LAST_WR   = CNT_W'(NUM_RESULTS - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] push_data, fifo_head;

  assign in_ready = (state_q == RUN) && !fifo_full && (acc_cnt_q < FRAME_CNT);
  assign push     = in_valid && in_ready;
  // An ack only counts against an outstanding request.
  assign pop      = mem_req_q && mem_ack;

`ifdef RESULT_RELU_EN
  assign push_data = in_num[DATA_WIDTH-1] ? '0 : in_num;
`else
  assign push_data = in_num;
`endif

  result_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    acc_cnt_d   = acc_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = RUN;
          acc_cnt_d = '0;
          wr_cnt_d  = '0;
        end
      end
      RUN: begin
        if (push) acc_cnt_d = acc_cnt_q + CNT_W'(1);
        if (pop) begin
          mem_req_d = 1'b0;
          wr_cnt_d  = wr_cnt_q + CNT_W'(1);
          if (wr_cnt_q == LAST_WR) state_d = DONE;
        end else if (!mem_req_q && !fifo_empty) begin
          // Launch the next write; the head stays in the FIFO until acked.
          mem_req_d   = 1'b1;
          mem_addr_d  = ADDR_WIDTH'(wr_cnt_q);
          mem_wdata_d = fifo_head;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_cnt_q   <= acc_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule
